// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - bus between the SPI arbiter and the shared spi_master
interface spi_arbiter_if #(
  parameter int SLAVE_COUNT = 1
);
  logic [7:0]             tx_byte;
  logic                   tx_byte_valid;
  logic [SLAVE_COUNT-1:0] ss_in;
  logic                   spi_ready;
  logic [7:0]             rx_byte;
  logic                   rx_byte_valid;

  modport master (
    output tx_byte, tx_byte_valid, ss_in,
    input  spi_ready, rx_byte, rx_byte_valid
  );

  modport slave (
    input  tx_byte, tx_byte_valid, ss_in,
    output spi_ready, rx_byte, rx_byte_valid
  );
endinterface

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin sharing of one spi_master; define SPI_ARBITER_LOCK_EN for owner lock
module spi_arbiter #(
  parameter int REQ_COUNT   = 2,
  parameter int SLAVE_COUNT = 1,
  parameter int SEL_W       = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [REQ_COUNT-1:0]       req,
  input  logic [8*REQ_COUNT-1:0]     req_byte,
  input  logic [SEL_W*REQ_COUNT-1:0] req_slave,
  input  logic [REQ_COUNT-1:0]       req_lock,
  output logic [REQ_COUNT-1:0]       grant,
  output logic [REQ_COUNT-1:0]       done,
  output logic                       err,
  output logic [7:0]                 rx_data,
  spi_arbiter_if.master              spi
);
  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam logic [SEL_W:0] SLAVE_LIM = (SEL_W+1)'(SLAVE_COUNT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RX, WAIT_READY, BAD_SEL} state_t;

  state_t                 state, state_nx;
  logic [IDX_W-1:0]       rr_ptr, owner, owner_nx, pick_idx;
  logic [IDX_W:0]         cand;
  logic                   pick_found, pick_bad;
  logic [REQ_COUNT-1:0]   pick_oh;
  logic [7:0]             pick_byte, byte_q;
  logic [SEL_W-1:0]       pick_sel, sel_q;
  logic [SLAVE_COUNT-1:0] ss_sel;

  assign owner_nx = (owner == IDX_W'(REQ_COUNT-1)) ? '0 : owner + 1'b1;

`ifdef SPI_ARBITER_LOCK_EN
  logic lock_q;

  // remember in the done cycle whether the finishing owner wants the next turn
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   lock_q <= 1'b0;
    else if (|done) lock_q <= |(done & req_lock);
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // pick the winner: locked owner first, otherwise first raised req from rr_ptr with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
`ifdef SPI_ARBITER_LOCK_EN
    if (lock_q && req[owner]) begin
      pick_found = 1'b1;
      pick_idx   = owner;
    end
`endif
    for (int k = 0; k < REQ_COUNT; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(REQ_COUNT)) cand = cand - (IDX_W+1)'(REQ_COUNT);
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // one-hot grant, byte and slave index of the picked requester
  always_comb begin
    pick_oh   = '0;
    pick_byte = '0;
    pick_sel  = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_oh[i] = 1'b1;
        pick_byte  = req_byte[8*i +: 8];
        pick_sel   = req_slave[SEL_W*i +: SEL_W];
      end
    end
    pick_bad = ({1'b0, pick_sel} >= SLAVE_LIM);
  end

  // active-low select for the latched slave index
  always_comb begin
    ss_sel = '1;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      if (sel_q == SEL_W'(s)) ss_sel[s] = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state and spi_master drive; the master only sees activity during ISSUE
  always_comb begin
    state_nx          = state;
    spi.tx_byte_valid = 1'b0;
    spi.tx_byte       = '0;
    spi.ss_in         = '1;
    case (state)
      IDLE:       if (spi.spi_ready && pick_found) state_nx = pick_bad ? BAD_SEL : ISSUE;
      ISSUE: begin
        spi.tx_byte_valid = 1'b1;
        spi.tx_byte       = byte_q;
        spi.ss_in         = ss_sel;
        state_nx          = WAIT_RX;
      end
      WAIT_RX:    if (spi.rx_byte_valid) state_nx = WAIT_READY;
      WAIT_READY: if (spi.spi_ready) state_nx = IDLE;
      BAD_SEL:    state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // grant/latch on arbitration, done/err pulses, rx capture and pointer advance after each done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant   <= '0;
      done    <= '0;
      err     <= 1'b0;
      rx_data <= 8'h00;
      byte_q  <= 8'h00;
      sel_q   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      if (|done) rr_ptr <= owner_nx;
      case (state)
        IDLE: begin
          if (spi.spi_ready && pick_found) begin
            grant  <= pick_oh;
            owner  <= pick_idx;
            byte_q <= pick_byte;
            sel_q  <= pick_sel;
            if (pick_bad) begin
              done    <= pick_oh;
              err     <= 1'b1;
              rx_data <= 8'h00;
            end
          end
        end
        WAIT_RX: begin
          if (spi.rx_byte_valid) begin
            rx_data <= spi.rx_byte;
            done    <= grant;
          end
        end
        WAIT_READY: if (spi.spi_ready) grant <= '0;
        BAD_SEL:    grant <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter REQ_COUNT, default 2: number of requesters sharing one spi_master; SHALL be >= 2.
REQ-002 Parameter SLAVE_COUNT, default 1: width of ss_in; SHALL match the attached spi_master.
REQ-003 Parameter SEL_W, default $clog2(SLAVE_COUNT) floored at 1: width of each slave index.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  REQ_COUNT  per-requester level request; held until that requester's done pulse.
REQ-007 req_byte  input  8*REQ_COUNT  byte to send; requester i at bits [8i+7:8i].
REQ-008 req_slave  input  SEL_W*REQ_COUNT  target slave index; requester i at bits [SEL_W*i+SEL_W-1:SEL_W*i].
REQ-009 req_lock  input  REQ_COUNT  keep-grant request (Configuration section).
REQ-010 grant  output  REQ_COUNT  one-hot owner of the current transaction; all zero when idle.
REQ-011 done  output  REQ_COUNT  one-cycle pulse to the owner at transaction end.
REQ-012 err  output  1  one-cycle pulse coincident with done when the slave index is invalid.
REQ-013 rx_data  output  8  received byte; valid in the done cycle and held until the next done.
REQ-014 tx_byte, tx_byte_valid, ss_in  outputs  8/1/SLAVE_COUNT  drive the spi_master inputs of the same names.
REQ-015 spi_ready, rx_byte, rx_byte_valid  inputs  1/8/1  from the spi_master outputs of the same names.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT_RX, WAIT_READY and BAD_SEL.
REQ-017 IDLE: when spi_ready=1 and any req bit is high, the arbiter SHALL select one requester, set grant, and latch its byte and slave index in the same edge.
REQ-018 Selection SHALL be round-robin: search starts at index rr_ptr and wraps past REQ_COUNT-1 to 0. After each done, rr_ptr SHALL become the owner index + 1, with wrap.
REQ-019 If the latched slave index is >= SLAVE_COUNT, the next state SHALL be BAD_SEL. Otherwise it SHALL be ISSUE.
REQ-020 ISSUE lasts exactly 1 cycle. In it the arbiter SHALL drive tx_byte_valid=1, tx_byte=latched byte, and ss_in all ones except bit[index]=0, then go to WAIT_RX.
REQ-021 Outside ISSUE, tx_byte_valid SHALL be 0 and ss_in SHALL be all ones.
REQ-022 WAIT_RX: on rx_byte_valid=1, rx_data SHALL capture rx_byte, the owner's done SHALL pulse on the next cycle, and the next state SHALL be WAIT_READY.
REQ-023 WAIT_READY: the arbiter SHALL wait for spi_ready=1, then clear grant and return to IDLE. No new grant is issued before spi_ready is high.
REQ-024 BAD_SEL: the arbiter SHALL pulse done[owner] and err for 1 cycle with rx_data=8'h00, issue no SPI activity, and return to IDLE.
REQ-025 A req bit that falls before it is granted SHALL be treated as withdrawn. A req bit that falls after grant SHALL NOT abort the transaction.
REQ-026 Requests arriving while a transaction is in progress SHALL wait. No request SHALL be lost while its req stays high.
REQ-027 Latency from grant to ISSUE SHALL be 1 cycle. Latency from rx_byte_valid to done SHALL be 1 cycle.

Reset
REQ-028 When reset_n=0, the arbiter SHALL immediately set: state=IDLE, grant=0, done=0, err=0, rx_data=0, tx_byte=0, tx_byte_valid=0, ss_in=all ones, rr_ptr=0.
REQ-029 A reset in the middle of a transaction SHALL abandon it with no done pulse. The arbiter and spi_master SHALL be reset together.

Configuration
REQ-030 Macro SPI_ARBITER_LOCK_EN, when defined: if req_lock[owner]=1 in the done cycle, the next grant SHALL go to the same owner when its req is high, overriding round-robin. If that req is low, normal round-robin arbitration SHALL resume.
REQ-031 Macro SPI_ARBITER_LOCK_EN, when undefined: req_lock SHALL be ignored and arbitration SHALL be pure round-robin.

Verification
REQ-032 REQ_COUNT=2, req=2'b01, byte 8'hA5, slave 0, miso loopback -> one ISSUE cycle with ss_in=0, then done=2'b01 with rx_data=8'hA5.
REQ-033 req=2'b11 held high, lock disabled -> grants alternate 01,10,01,10 over four transactions, starting from rr_ptr=0.
REQ-034 SLAVE_COUNT=2, req_slave=3 (SEL_W=1 forced to 2) -> done and err pulse within 2 cycles, tx_byte_valid stays 0, rx_data=8'h00.
REQ-035 With SPI_ARBITER_LOCK_EN, req=2'b11 and req_lock=2'b01 -> requester 0 is granted 3 times in a row. Dropping req_lock then gives the next grant to requester 1.
REQ-036 reset_n pulsed low during WAIT_RX -> grant=0 and ss_in=all ones immediately, no done pulse. The next request completes normally.
